// File: rtl/c2h_pkt_arbiter_if.sv
// Handshake bundle for the C2H packet arbiter: NumChnl upstream AXIS lanes plus one merged
// downstream AXIS stream. The arbiter connects through the slave modport.
interface c2h_pkt_arbiter_if #(
  parameter int unsigned NumChnl = 4,
  parameter int unsigned DataW   = 64,
  parameter int unsigned IdW     = 2
);
  logic [NumChnl-1:0]       s_tvalid;
  logic [NumChnl-1:0]       s_tready;
  logic [NumChnl-1:0]       s_tlast;
  logic [NumChnl*DataW-1:0] s_tdata;
  logic                     m_tvalid;
  logic                     m_tready;
  logic                     m_tlast;
  logic [DataW-1:0]         m_tdata;
  logic [IdW-1:0]           m_tid;

  modport master (
    output s_tvalid, s_tlast, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tlast, m_tdata, m_tid
  );

  modport slave (
    input  s_tvalid, s_tlast, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tlast, m_tdata, m_tid
  );
endinterface

// File: rtl/c2h_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging NumChnl C2H AXIS streams through a 2-entry skid
// buffer. Define C2H_PKT_ARB_STATS_EN to build the per-channel forwarded-packet counters.
module c2h_pkt_arbiter #(
  parameter int unsigned NumChnl = 4,
  parameter int unsigned DataW   = 64,
  parameter int unsigned IdW     = (NumChnl > 2) ? $clog2(NumChnl) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  c2h_pkt_arbiter_if.slave        axis_io,
  output logic [NumChnl-1:0]      grant_o,
  input  logic                    stat_clr_i,
  output logic [NumChnl*32-1:0]   stat_pkt_cnt_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  typedef struct packed {
    logic             last;
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
  } beat_t;

  state_e             state_q, state_d;
  logic [NumChnl-1:0] grant_q, grant_d;
  logic [IdW-1:0]     gidx_q, gidx_d;
  logic [IdW-1:0]     last_q, last_d;

  beat_t out_q, out_d, skid_q, skid_d, in_beat;
  logic  out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;

  logic               pick_found;
  logic [IdW-1:0]     pick_idx, cand;
  logic [NumChnl-1:0] s_ready;
  logic               push, pop;

  // Round-robin search starting just after the last channel served.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NumChnl; i++) begin
      cand = IdW'((32'(last_q) + i) % NumChnl);
      if (!pick_found && axis_io.s_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign in_beat.last = axis_io.s_tlast[gidx_q];
  assign in_beat.id   = gidx_q;
  assign in_beat.data = axis_io.s_tdata[gidx_q*DataW +: DataW];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IdW'(NumChnl - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StBusy;
          gidx_d  = pick_idx;
          grant_d = NumChnl'(1) << pick_idx;
        end
      end
      StBusy: begin
        if (push && in_beat.last) begin
          state_d = StIdle;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ready depends only on flops, so M_TREADY never reaches S_TREADY combinationally.
  always_comb begin
    s_ready = '0;
    if (state_q == StBusy && !skid_vld_q) begin
      s_ready = grant_q;
    end
  end

  assign push             = |(s_ready & axis_io.s_tvalid);
  assign pop              = out_vld_q & axis_io.m_tready;
  assign axis_io.s_tready = s_ready;
  assign grant_o          = grant_q;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (pop || !out_vld_q) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = push;
        if (push) begin
          out_d = in_beat;
        end
      end
    end else if (push) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign axis_io.m_tvalid = out_vld_q;
  assign axis_io.m_tlast  = out_q.last;
  assign axis_io.m_tdata  = out_q.data;
  assign axis_io.m_tid    = out_q.id;

`ifdef C2H_PKT_ARB_STATS_EN
  logic [NumChnl-1:0][31:0] stat_q, stat_d;

  // Clear has priority over a same-cycle packet completion.
  always_comb begin
    stat_d = stat_q;
    if (stat_clr_i) begin
      stat_d = '0;
    end else if (pop && out_q.last) begin
      for (int unsigned ch = 0; ch < NumChnl; ch++) begin
        if (32'(out_q.id) == ch) begin
          stat_d[ch] = stat_q[ch] + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_pkt_cnt_o = stat_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign stat_pkt_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_c2h_pkt_arbiter.sv
// Directed bench for c2h_pkt_arbiter: grant order, grant lock, skid behaviour under
// backpressure, asynchronous reset and (with C2H_PKT_ARB_STATS_EN) the packet counters.
module tb_c2h_pkt_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 64;
  localparam int unsigned IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   grant;
  logic           stat_clr = 1'b0;
  logic [N*32-1:0] stat;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int stall_viol = 0;
  bit rand_rdy = 1'b0;

  logic [W-1:0]  m_data_q[$];
  logic [IW-1:0] m_tid_q[$];
  logic          m_last_q[$];
  int            m_cyc_q[$];
  int            s_cyc_q[$];
  logic [N-1:0]  s_grant_q[$];

  logic [W-1:0]  exp_d[$];
  logic [IW-1:0] exp_t[$];
  logic          exp_l[$];

  always #5 clk = ~clk;

  c2h_pkt_arbiter_if #(.NumChnl(N), .DataW(W), .IdW(IW)) ifc ();

  c2h_pkt_arbiter #(.NumChnl(N), .DataW(W), .IdW(IW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .axis_io        (ifc.slave),
    .grant_o        (grant),
    .stat_clr_i     (stat_clr),
    .stat_pkt_cnt_o (stat)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Handshake monitor, sampled mid-cycle; inputs only change just after posedge.
  initial begin
    logic          prev_stall;
    logic [W+IW:0] prev_beat;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifc.m_tvalid && ifc.m_tready) begin
          m_data_q.push_back(ifc.m_tdata);
          m_tid_q.push_back(ifc.m_tid);
          m_last_q.push_back(ifc.m_tlast);
          m_cyc_q.push_back(cyc);
        end
        if (|(ifc.s_tvalid & ifc.s_tready)) begin
          s_cyc_q.push_back(cyc);
          s_grant_q.push_back(grant);
        end
        if (prev_stall && (!ifc.m_tvalid || {ifc.m_tlast, ifc.m_tid, ifc.m_tdata} != prev_beat))
          stall_viol++;
        prev_stall = ifc.m_tvalid && !ifc.m_tready;
      end else begin
        prev_stall = 1'b0;
      end
      prev_beat = {ifc.m_tlast, ifc.m_tid, ifc.m_tdata};
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) ifc.m_tready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input int ch, input logic [63:0] d, input logic l);
    int t;
    t = 0;
    ifc.s_tvalid[ch] = 1'b1;
    ifc.s_tdata[ch*W +: W] = d;
    ifc.s_tlast[ch] = l;
    @(negedge clk);
    while (!ifc.s_tready[ch] && t < 300) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("s_accept_ch%0d", ch), 64'(ifc.s_tready[ch]), 64'd1);
    @(posedge clk);
    #1;
    ifc.s_tvalid[ch] = 1'b0;
    ifc.s_tlast[ch] = 1'b0;
  endtask

  task automatic send_pkt(input int ch, input int n, input logic [63:0] base);
    for (int b = 0; b < n; b++) send_beat(ch, base + 64'(b), b == n - 1);
  endtask

  task automatic run_all4();
    fork
      begin send_pkt(0, 2, 64'h00); send_pkt(0, 2, 64'h02); end
      begin send_pkt(1, 2, 64'h10); send_pkt(1, 2, 64'h12); end
      begin send_pkt(2, 2, 64'h20); send_pkt(2, 2, 64'h22); end
      begin send_pkt(3, 2, 64'h30); send_pkt(3, 2, 64'h32); end
    join
  endtask

  task automatic drain();
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    m_data_q.delete(); m_tid_q.delete(); m_last_q.delete(); m_cyc_q.delete();
    s_cyc_q.delete(); s_grant_q.delete();
    exp_d.delete(); exp_t.delete(); exp_l.delete();
  endtask

  task automatic exp_push(input logic [63:0] d, input int t, input logic l);
    exp_d.push_back(d);
    exp_t.push_back(IW'(t));
    exp_l.push_back(l);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, 64'(m_data_q.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < m_data_q.size()) begin
        check($sformatf("%s_data%0d", tag, i), m_data_q[i], exp_d[i]);
        check($sformatf("%s_tid%0d", tag, i), 64'(m_tid_q[i]), 64'(exp_t[i]));
        check($sformatf("%s_last%0d", tag, i), 64'(m_last_q[i]), 64'(exp_l[i]));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.s_tvalid = '0;
    ifc.s_tlast = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_all4();
    int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int k = 0; k < 8; k++)
      for (int b = 0; b < 2; b++)
        exp_push(64'(order[k] * 16 + (k / 4) * 2 + b), order[k], b == 1);
  endtask

  initial begin
    ifc.s_tvalid = '0;
    ifc.s_tlast = '0;
    ifc.s_tdata = '0;
    ifc.m_tready = 1'b1;

    // Reset values
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_tvalid", 64'(ifc.m_tvalid), 64'd0);
    check("rst_m_tlast", 64'(ifc.m_tlast), 64'd0);
    check("rst_m_tdata", ifc.m_tdata, 64'd0);
    check("rst_m_tid", 64'(ifc.m_tid), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_s_tready", 64'(ifc.s_tready), 64'd0);
    check("rst_stat", 64'(stat[63:0] | stat[127:64]), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single requester, two back-to-back packets
    clear_mon();
    send_pkt(1, 4, 64'd1);
    send_pkt(1, 4, 64'd5);
    drain();
    for (int i = 0; i < 8; i++) exp_push(64'(i + 1), 1, i == 3 || i == 7);
    check_stream("t1");
    check("t1_s_count", 64'(s_cyc_q.size()), 64'd8);
    if (s_cyc_q.size() == 8 && m_cyc_q.size() == 8) begin
      check("t1_throughput", 64'(s_cyc_q[3] - s_cyc_q[0]), 64'd3);
      check("t1_pkt_gap", 64'(s_cyc_q[4] - s_cyc_q[3]), 64'd2);
      check("t1_latency", 64'(m_cyc_q[0] - s_cyc_q[0]), 64'd1);
      check("t1_grant_a", 64'(s_grant_q[0]), 64'b0010);
      check("t1_grant_b", 64'(s_grant_q[6]), 64'b0010);
    end
    check("t1_grant_idle", 64'(grant), 64'd0);

    // 2: all four requesting from reset
    do_reset();
    clear_mon();
    run_all4();
    drain();
    exp_all4();
    check_stream("t2");

    // 3: grant lock while the granted channel idles mid-packet (last pointer is 3 here)
    clear_mon();
    fork
      begin
        send_beat(2, 64'h20, 1'b0);
        send_beat(2, 64'h21, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("t3_grant_hold", 64'(grant), 64'b0100);
        check("t3_ch0_blocked", 64'(ifc.s_tready[0]), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        send_beat(2, 64'h22, 1'b0);
        send_beat(2, 64'h23, 1'b1);
      end
      begin
        @(posedge clk);
        #1;
        send_pkt(0, 2, 64'h00);
      end
    join
    drain();
    for (int i = 0; i < 4; i++) exp_push(64'(32'h20 + i), 2, i == 3);
    exp_push(64'h00, 0, 1'b0);
    exp_push(64'h01, 0, 1'b1);
    check_stream("t3");

    // 4: random downstream backpressure, same traffic as test 2
    do_reset();
    clear_mon();
    stall_viol = 0;
    rand_rdy = 1'b1;
    run_all4();
    rand_rdy = 1'b0;
    ifc.m_tready = 1'b1;
    drain();
    exp_all4();
    check_stream("t4");
    check("t4_stall_stable", 64'(stall_viol), 64'd0);

    // 5: asynchronous reset in the middle of a packet
    send_pkt(0, 1, 64'h40);
    send_beat(1, 64'h41, 1'b0);
    ifc.s_tvalid[1] = 1'b1;
    ifc.s_tdata[1*W +: W] = 64'h42;
    #2;
    check("t5_pre_valid", 64'(ifc.m_tvalid), 64'd1);
    check("t5_pre_data", ifc.m_tdata, 64'h41);
    rst_n = 1'b0;
    #1;
    check("t5_m_tvalid", 64'(ifc.m_tvalid), 64'd0);
    check("t5_m_tdata", ifc.m_tdata, 64'd0);
    check("t5_m_tid", 64'(ifc.m_tid), 64'd0);
    check("t5_grant", 64'(grant), 64'd0);
    check("t5_s_tready", 64'(ifc.s_tready), 64'd0);
    ifc.s_tvalid = '0;
    ifc.s_tlast = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
    fork
      send_pkt(2, 2, 64'h70);
      send_pkt(1, 2, 64'h60);
      send_pkt(0, 2, 64'h50);
    join
    drain();
    exp_push(64'h50, 0, 1'b0); exp_push(64'h51, 0, 1'b1);
    exp_push(64'h60, 1, 1'b0); exp_push(64'h61, 1, 1'b1);
    exp_push(64'h70, 2, 1'b0); exp_push(64'h71, 2, 1'b1);
    check_stream("t5");

`ifdef C2H_PKT_ARB_STATS_EN
    // 6: packet counters
    for (int p = 0; p < 3; p++) send_pkt(3, 1, 64'(p));
    drain();
    check("t6_cnt3", 64'(stat[127:96]), 64'd3);
    check("t6_cnt0", 64'(stat[31:0]), 64'd1);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check("t6_clr", 64'(stat[63:0] | stat[127:64]), 64'd0);
    stat_clr = 1'b1;
    send_pkt(3, 1, 64'h33);
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    drain();
    check("t6_clr_wins", 64'(stat[127:96]), 64'd0);
    force dut.stat_q = {32'hFFFF_FFFF, 96'h0};
    #1;
    release dut.stat_q;
    check("t6_preload", 64'(stat[127:96]), 64'hFFFF_FFFF);
    send_pkt(3, 1, 64'h34);
    drain();
    check("t6_wrap", 64'(stat[127:96]), 64'd0);
`else
    check("t6_stat_tied", 64'(stat[63:0] | stat[127:64]), 64'd0);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check("t6_stat_tied_clr", 64'(stat[63:0] | stat[127:64]), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
